// File: rtl/sinc_pkg.sv
// Shared constants, types and helpers for the sinc3 decimation filter.
//   ACC_W      : accumulator / output width
//   DEC_MIN/MAX: supported decimation ratio range
//   SETTLE_CNT : comb results discarded after reset or flush
//   clamp_dec  : limits a requested ratio to the supported range
`timescale 1ns/1ps
package sinc_pkg;

  localparam int ACC_W      = 25;
  localparam int DEC_MIN    = 2;
  localparam int DEC_MAX    = 256;
  localparam int DEC_W      = 9;
  localparam int SETTLE_CNT = 3;

  typedef logic [ACC_W-1:0] acc_t;

  function automatic logic [DEC_W-1:0] clamp_dec(input logic [DEC_W-1:0] dec,
                                                 input int dmin,
                                                 input int dmax);
    if (int'(dec) < dmin) return DEC_W'(dmin);
    if (int'(dec) > dmax) return DEC_W'(dmax);
    return dec;
  endfunction

endpackage

// File: rtl/sinc3_comb.sv
// Three-stage registered differentiator (comb) for the sinc3 decimator.
//   sys_clk  : clock, rising edge
//   reset    : synchronous, active-high
//   flush    : clears all delays and any event in flight
//   comb_ev  : one-cycle strobe, i3 holds a new decimated integrator value
//   i3       : third integrator output
//   c3       : comb result, valid while c3_valid is high
//   c3_valid : one-cycle strobe, three cycles after comb_ev
`timescale 1ns/1ps
module sinc3_comb
  import sinc_pkg::*;
#(
  parameter int ACC_W = sinc_pkg::ACC_W
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             comb_ev,
  input  logic [ACC_W-1:0] i3,
  output logic [ACC_W-1:0] c3,
  output logic             c3_valid
);

  // Index 0 is the pipeline input; index n is the output of stage n.
  logic [3:0][ACC_W-1:0] stage_d;
  logic [3:0]            stage_v;

  assign stage_d[0] = i3;
  assign stage_v[0] = comb_ev;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stage
      logic [ACC_W-1:0] z_reg;
      logic [ACC_W-1:0] diff_reg;
      logic             vld_reg;

      always_ff @(posedge sys_clk) begin
        if (reset || flush) begin
          z_reg    <= '0;
          diff_reg <= '0;
          vld_reg  <= 1'b0;
        end else begin
          vld_reg <= stage_v[gi];
          if (stage_v[gi]) begin
            // Modulo 2^ACC_W difference undoes the integrator wrap.
            diff_reg <= stage_d[gi] - z_reg;
            z_reg    <= stage_d[gi];
          end
        end
      end

      assign stage_d[gi+1] = diff_reg;
      assign stage_v[gi+1] = vld_reg;
    end
  endgenerate

  assign c3       = stage_d[3];
  assign c3_valid = stage_v[3];

endmodule

// File: rtl/sinc3_decim_filter.sv
// Sinc3 (order-3 CIC) decimator for a 1-bit sigma-delta bitstream.
//   sys_clk    : clock, rising edge
//   reset      : synchronous, active-high
//   enable     : 1 = run, 0 = hold filter state (comb in flight completes)
//   MCLK       : modulator clock, synchronous to sys_clk; rising edge samples
//   MDAT       : modulator bitstream, asynchronous (2-flop synchroniser)
//   DEC        : decimation ratio, clamped to DEC_MIN..DEC_MAX
//   flush      : one-cycle pulse restarting the filter
//   trip_hi/lo : unsigned over-range thresholds
//   trip_clr   : clears the sticky trip flag
//   data_out   : decimated unsigned sample, 0..D^3
//   data_valid : one-cycle strobe for a new data_out
//   trip       : sticky over-range flag
`timescale 1ns/1ps
module sinc3_decim_filter
  import sinc_pkg::*;
#(
  parameter int ACC_W   = sinc_pkg::ACC_W,
  parameter int DEC_MAX = sinc_pkg::DEC_MAX,
  parameter int DEC_MIN = sinc_pkg::DEC_MIN
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             MCLK,
  input  logic             MDAT,
  input  logic [8:0]       DEC,
  input  logic             flush,
  input  logic [ACC_W-1:0] trip_hi,
  input  logic [ACC_W-1:0] trip_lo,
  input  logic             trip_clr,
  output logic [ACC_W-1:0] data_out,
  output logic             data_valid,
  output logic             trip
);

  logic             mdat_s1_reg, mdat_s2_reg, mclk_d_reg;
  logic             sample_en;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] i1_reg, i2_reg, i3_reg;
  logic [DEC_W-1:0] d_reg, cnt_reg, dec_clamped;
  logic             comb_ev_reg;
  logic [1:0]       settle_reg;
  logic [ACC_W-1:0] c3;
  logic             c3_valid;
  logic [ACC_W-1:0] data_out_reg;
  logic             data_valid_reg;
  logic             trip_reg;

  // Input conditioning runs regardless of enable so that re-enabling never
  // sees a stale MCLK level and fabricates an edge.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      mdat_s1_reg <= 1'b0;
      mdat_s2_reg <= 1'b0;
      mclk_d_reg  <= 1'b0;
    end else begin
      mdat_s1_reg <= MDAT;
      mdat_s2_reg <= mdat_s1_reg;
      mclk_d_reg  <= MCLK;
    end
  end

  assign sample_en   = MCLK & ~mclk_d_reg & enable;
  assign x           = {{(ACC_W-1){1'b0}}, mdat_s2_reg};
  assign dec_clamped = clamp_dec(DEC, DEC_MIN, DEC_MAX);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      i1_reg         <= '0;
      i2_reg         <= '0;
      i3_reg         <= '0;
      cnt_reg        <= '0;
      d_reg          <= dec_clamped;   // last reset cycle latches the ratio
      comb_ev_reg    <= 1'b0;
      settle_reg     <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else if (flush) begin
      i1_reg         <= '0;
      i2_reg         <= '0;
      i3_reg         <= '0;
      cnt_reg        <= '0;
      d_reg          <= dec_clamped;
      comb_ev_reg    <= 1'b0;
      settle_reg     <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      comb_ev_reg    <= 1'b0;
      data_valid_reg <= 1'b0;
      if (sample_en) begin
        // All three integrators advance from their old values.
        i1_reg <= i1_reg + x;
        i2_reg <= i2_reg + i1_reg;
        i3_reg <= i3_reg + i2_reg;
        if (cnt_reg == d_reg - DEC_W'(1)) begin
          cnt_reg     <= '0;
          comb_ev_reg <= 1'b1;
          d_reg       <= dec_clamped;  // DEC changes apply at the boundary
        end else begin
          cnt_reg <= cnt_reg + DEC_W'(1);
        end
      end
      if (c3_valid) begin
        // Until the comb delays hold real history the result is garbage.
        if (settle_reg < 2'(SETTLE_CNT)) begin
          settle_reg <= settle_reg + 2'd1;
        end else begin
          data_out_reg   <= c3;
          data_valid_reg <= 1'b1;
        end
      end
    end
  end

  sinc3_comb #(
    .ACC_W (ACC_W)
  ) u_comb (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .flush    (flush),
    .comb_ev  (comb_ev_reg),
    .i3       (i3_reg),
    .c3       (c3),
    .c3_valid (c3_valid)
  );

  // Trip is evaluated on the cycle the new sample is presented; a trip
  // condition beats a simultaneous clear. Flush leaves it alone.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      trip_reg <= 1'b0;
    end else if (data_valid_reg &&
                 ((data_out_reg > trip_hi) || (data_out_reg < trip_lo))) begin
      trip_reg <= 1'b1;
    end else if (trip_clr) begin
      trip_reg <= 1'b0;
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign trip       = trip_reg;

endmodule

// File: tb/tb_sinc3_decim_filter.sv
`timescale 1ns/1ps
module tb_sinc3_decim_filter;
  import sinc_pkg::*;

  logic             sys_clk = 1'b0;
  logic             reset, enable, MCLK, MDAT, flush, trip_clr;
  logic [8:0]       DEC;
  logic [ACC_W-1:0] trip_hi, trip_lo;
  logic [ACC_W-1:0] data_out;
  logic             data_valid, trip;

  sinc3_decim_filter dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .enable     (enable),
    .MCLK       (MCLK),
    .MDAT       (MDAT),
    .DEC        (DEC),
    .flush      (flush),
    .trip_hi    (trip_hi),
    .trip_lo    (trip_lo),
    .trip_clr   (trip_clr),
    .data_out   (data_out),
    .data_valid (data_valid),
    .trip       (trip)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] val;
    int          due;
  } sb_t;
  sb_t sb[$];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: samples since the last restart.
  bit hist[$];
  int m_cnt    = 0;
  int m_frames = 0;
  int m_d      = 16;
  bit alt_bit  = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  function automatic int model_clamp(input logic [8:0] dec);
    if (dec < 9'd2)   return 2;
    if (dec > 9'd256) return 256;
    return int'(dec);
  endfunction

  // Direct FIR form of sinc3: taps are the triple convolution of a
  // length-D box; the integrator chain adds two samples of delay.
  function automatic logic [63:0] fir_expected();
    longint acc;
    int     d;
    int     m;
    acc = 0;
    d   = m_d;
    m   = hist.size() - 1;
    for (int k = 0; k <= 3*d-3; k++) begin
      int idx;
      idx = m - 2 - k;
      if (idx >= 0 && hist[idx]) begin
        longint hk;
        int     jlo, jhi;
        hk  = 0;
        jlo = (k - d + 1 > 0) ? k - d + 1 : 0;
        jhi = (k < 2*d - 2) ? k : 2*d - 2;
        for (int j = jlo; j <= jhi; j++)
          hk += (j + 1 < 2*d - 1 - j) ? j + 1 : 2*d - 1 - j;
        acc += hk;
      end
    end
    return 64'(acc & ((longint'(1) << ACC_W) - 1));
  endfunction

  task automatic model_restart();
    hist.delete();
    sb.delete();
    m_cnt    = 0;
    m_frames = 0;
    m_d      = model_clamp(DEC);
  endtask

  // Called just before the sys_clk edge that sees the MCLK rising edge.
  task automatic model_sample(input logic xb, input logic fl);
    if (fl) begin
      model_restart();
    end else if (enable) begin
      hist.push_back(xb);
      m_cnt++;
      if (m_cnt == m_d) begin
        m_cnt = 0;
        m_frames++;
        if (m_frames > SETTLE_CNT)
          sb.push_back('{val: fir_expected(), due: cyc + 5});
        m_d = model_clamp(DEC);
      end
    end
  endtask

  always @(negedge sys_clk) begin
    if (reset === 1'b0 && data_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 64'(data_valid), 64'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        $display("valid @cycle %0d data_out=%0d expected=%0d trip=%0b",
                 cyc, data_out, e.val, trip);
        check_val("data_out", 64'(data_out), e.val);
        check_val("latency", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // One 8-cycle MCLK period: 4 low, 4 high; sample taken on the rise.
  task automatic mclk_period(input logic mdat, input logic fl);
    @(posedge sys_clk); #1;
    MCLK = 1'b0;
    MDAT = mdat;
    repeat (4) @(posedge sys_clk);
    #1;
    MCLK  = 1'b1;
    flush = fl;
    model_sample(mdat, fl);
    @(posedge sys_clk); #1;
    flush = 1'b0;
    repeat (2) @(posedge sys_clk);
  endtask

  // mode 0: all zeros, 1: all ones, 2: alternating
  task automatic run_samples(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      logic b;
      if (mode == 2) begin
        b = alt_bit;
        alt_bit = ~alt_bit;
      end else begin
        b = (mode == 1);
      end
      mclk_period(b, 1'b0);
    end
  endtask

  task automatic do_flush();
    tick(6);
    flush = 1'b1;
    model_restart();
    tick(1);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    #1;
    MCLK  = 1'b0;
    reset = 1'b1;
    model_restart();
    tick(3);
    reset = 1'b0;
  endtask

  initial begin
    repeat (60000) @(posedge sys_clk);
    $display("FAIL watchdog: got timeout at cycle %0d required completion", cyc);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    MCLK     = 1'b0;
    MDAT     = 1'b0;
    flush    = 1'b0;
    trip_clr = 1'b0;
    DEC      = 9'd16;
    trip_hi  = ACC_W'(1 << 24);
    trip_lo  = '0;

    do_reset();
    check_val("reset_data_out", 64'(data_out), 64'd0);
    check_val("reset_valid", 64'(data_valid), 64'd0);
    check_val("reset_trip", 64'(trip), 64'd0);

    // Constant ones, D=16: settled output 4096, no trip.
    run_samples(7*16, 1);
    tick(8);
    check_val("ones_d16_out", 64'(data_out), 64'd4096);
    check_val("ones_no_trip", 64'(trip), 64'd0);

    // Constant zeros with trip_lo=1: trips only on settled outputs.
    trip_lo = ACC_W'(1);
    do_flush();
    run_samples(3*16, 0);
    tick(8);
    check_val("trip_before_settle", 64'(trip), 64'd0);
    run_samples(16, 0);
    tick(8);
    check_val("zeros_out", 64'(data_out), 64'd0);
    check_val("trip_set_lo", 64'(trip), 64'd1);
    trip_clr = 1'b1;
    tick(1);
    trip_clr = 1'b0;
    check_val("trip_cleared", 64'(trip), 64'd0);
    run_samples(16, 0);
    tick(8);
    check_val("trip_reset_again", 64'(trip), 64'd1);
    trip_lo  = '0;
    trip_clr = 1'b1;
    tick(1);
    trip_clr = 1'b0;
    check_val("trip_cleared2", 64'(trip), 64'd0);

    // Alternating input: settled output 2048, latency checked per sample.
    do_flush();
    run_samples(6*16, 2);
    tick(8);
    check_val("alt_out", 64'(data_out), 64'd2048);

    // Ratio clamping, low and high; D=256 wraps the integrators.
    DEC = 9'd1;
    do_flush();
    run_samples(6*2, 1);
    tick(8);
    check_val("dec_min_out", 64'(data_out), 64'd8);
    DEC = 9'd300;
    do_flush();
    run_samples(5*256, 1);
    tick(8);
    check_val("dec_max_out", 64'(data_out), 64'd16777216);

    // Flush coincident with a sample, mid-frame; trip held across it.
    DEC     = 9'd16;
    trip_hi = ACC_W'(100);
    do_flush();
    run_samples(4*16 + 5, 1);
    tick(2);
    check_val("trip_hi_set", 64'(trip), 64'd1);
    mclk_period(1'b1, 1'b1);
    tick(2);
    check_val("flush_trip_kept", 64'(trip), 64'd1);
    check_val("flush_hold_out", 64'(data_out), 64'd4096);
    run_samples(3*16, 1);
    tick(8);
    check_val("flush_hold_out2", 64'(data_out), 64'd4096);
    check_val("flush_no_valid", 64'(data_valid), 64'd0);
    run_samples(16, 1);
    tick(8);

    // Reset while a comb result is in flight.
    run_samples(16, 1);
    do_reset();
    check_val("midreset_out", 64'(data_out), 64'd0);
    check_val("midreset_valid", 64'(data_valid), 64'd0);
    check_val("midreset_trip", 64'(trip), 64'd0);
    trip_hi = ACC_W'(1 << 24);
    run_samples(5*16, 1);
    tick(8);
    check_val("post_reset_out", 64'(data_out), 64'd4096);
    check_val("post_reset_trip", 64'(trip), 64'd0);

    // enable=0 right after a boundary (comb completes) and mid-frame.
    run_samples(16, 1);
    #1 enable = 1'b0;
    run_samples(6, 1);
    tick(2);
    enable = 1'b1;
    run_samples(8, 1);
    #1 enable = 1'b0;
    run_samples(6, 1);
    tick(2);
    enable = 1'b1;
    run_samples(8, 1);
    tick(8);
    check_val("enable_resume_out", 64'(data_out), 64'd4096);

    tick(10);
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sinc3_decim_filter.md
Name: sinc3_decim_filter

Overview:
Sinc3 (CIC, order 3) decimation filter for the 1-bit sigma-delta modulator data stream. It consumes MCLK, generated in the sys_clk domain by the modulator clock divider, and MDAT, returned from the external modulator. It produces decimated unsigned samples plus a sticky over-range trip flag for the motor-control current loop. It sits directly downstream of the modulator clock generator and upstream of the register/trip interface.

Parameters:
ACC_W, 25, accumulator/output width; must be at least 3*log2(DEC_MAX)+1.
DEC_MAX, 256, largest supported decimation ratio.
DEC_MIN, 2, smallest supported decimation ratio.

Ports:
sys_clk  in  1  system clock; all logic on its rising edge.
reset  in  1  synchronous, active-high; clock sys_clk.
enable  in  1  1 = run; 0 = freeze all state (no sampling).
MCLK  in  1  modulator clock, generated synchronously from sys_clk; no synchroniser.
MDAT  in  1  modulator bitstream, asynchronous.
DEC  in  9  decimation ratio; clamped to DEC_MIN..DEC_MAX.
flush  in  1  one-cycle pulse; restarts the filter.
trip_hi  in  ACC_W  upper trip threshold, unsigned.
trip_lo  in  ACC_W  lower trip threshold, unsigned.
trip_clr  in  1  clears the sticky trip flag.
data_out  out  ACC_W  decimated sample, unsigned, 0..D^3.
data_valid  out  1  one-cycle strobe; data_out is new.
trip  out  1  sticky over-range flag.

Behaviour:
- Reset: data_out=0, data_valid=0, trip=0. All integrators, comb delays, counters and the settle count are 0. mclk_d=0. The MDAT synchroniser flops are 0.
- MDAT passes through a 2-flop synchroniser to give mdat_s. mclk_d is MCLK registered. sample_en = MCLK & ~mclk_d & enable.
- Input mapping: x = mdat_s (0 or 1), zero-extended to ACC_W bits.
- Integrators update on sample_en only, all in parallel from the old values: i1<=i1+x; i2<=i2+i1; i3<=i3+i2.
- Integrator arithmetic is modulo 2^ACC_W. Wrap-around is required and is not an error.
- Decimation:
  - D = DEC clamped to [DEC_MIN, DEC_MAX]. D is latched at reset release, on flush, and at each decimation boundary. A DEC change therefore takes effect at the next boundary.
  - Sample counter cnt counts 0..D-1 on sample_en. On the sample_en where cnt==D-1, cnt returns to 0 and a comb event is issued.
- Comb: 3 registered stages, modulo 2^ACC_W.
  - Stage 1 (edge E+1): c1 = i3 - z0; z0 <= i3.
  - Stage 2 (edge E+2): c2 = c1 - z1; z1 <= c1.
  - Stage 3 (edge E+3): c3 = c2 - z2; z2 <= c2.
  - E is the edge on which the D-th sample is integrated.
  - data_out <= c3 and data_valid=1 for exactly one cycle after edge E+4. Latency from the D-th sample is 4 sys_clk cycles.
- Settling:
  - After reset or flush, the first 3 comb results are discarded. data_out and data_valid are not updated for them; a settle counter tracks 0..3.
  - The 4th and later results are output normally.
- flush: clears i1..i3, z0..z2, cnt, settle count, and any comb event in flight. It has priority over a sample_en or comb stage in the same cycle. data_out holds its last value. trip is unaffected.
- enable=0: sample_en is suppressed. A comb pipeline already in flight completes. All other state is held.
- Trip:
  - On each data_valid cycle, if data_out > trip_hi or data_out < trip_lo, trip <= 1. Comparison is unsigned, on the new value.
  - trip_clr clears trip to 0. If trip_clr and a trip condition occur in the same cycle, set wins.
- MCLK high/low times are at least 1 sys_clk cycle. No overlap of comb events is possible.

Decomposition:
- Package sinc_pkg:
  - constants ACC_W, DEC_MIN, DEC_MAX, SETTLE_CNT=3;
  - typedef acc_t (ACC_W-bit unsigned);
  - function clamp_dec.
- One sub-module, sinc3_comb: the 3-stage differentiator pipeline with the flush clear, and the comb-event-in / valid-out strobes.
- The integrators, counters, settle logic and trip logic stay in the top level.

Test Plan:
- MCLK period 8 cycles, MDAT=1 constant, DEC=16 -> first 3 results suppressed. Every later data_valid shows data_out=4096 (16^3), trip=0 with trip_hi=2^24, trip_lo=0.
- MDAT=0 constant, DEC=16 -> all settled outputs = 0. trip_lo=1 sets trip on the first valid. trip_clr then clears it, and it re-sets on the next valid.
- MDAT alternating 1,0 per sample, DEC=16 -> settled outputs = 2048. data_valid pulses exactly every 16 MCLK periods. Each pulse comes 4 sys_clk cycles after the 16th sample_en.
- DEC=1, then DEC=300 (MDAT=1) -> behaves as D=2 with output 8, then as D=256 with output 16777216. Observe integrator wrap with no output error.
- flush pulsed mid-frame, coincident with a sample_en -> no data_valid until 3 full D-sample periods have passed. data_out holds its old value meanwhile; trip is unchanged.
- reset asserted during the comb pipeline, and enable=0 for 50 cycles mid-frame -> reset zeroes all outputs and no stale valid appears. With enable=0 the count resumes exactly and the next output value is unchanged.
